// File: rtl/regfile_sb.sv
// Multi-port register file with per-entry pending scoreboard and a post-reset clear sweep.
// Define REGFILE_BYPASS_EN to forward same-cycle write data (and pending state) to the read ports.
module regfile_sb #(
  parameter int READ_PORTS  = 8,
  parameter int WRITE_PORTS = 4,
  parameter int ALLOC_PORTS = 4,
  parameter int WIDTH       = 32,
  parameter int DEPTH       = 64,
  parameter int ZERO_REG    = 1,
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [READ_PORTS-1:0][AW-1:0]         RA,
  output logic [READ_PORTS-1:0][WIDTH-1:0]      RD,
  output logic [READ_PORTS-1:0]                 RP,
  input  logic [WRITE_PORTS-1:0][AW-1:0]        WA,
  input  logic [WRITE_PORTS-1:0][WIDTH-1:0]     WD,
  input  logic [WRITE_PORTS-1:0]                We,
  input  logic [ALLOC_PORTS-1:0][AW-1:0]        AA,
  input  logic [ALLOC_PORTS-1:0]                Ae,
  output logic                                  ready
);

  typedef enum logic {INIT, RUN} state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     ptr_q, ptr_d;
  logic [WIDTH-1:0]  mem_q  [DEPTH];
  logic [WIDTH-1:0]  wr_dat [DEPTH];
  logic [DEPTH-1:0]  pend_q, pend_d, wr_hit;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (state_q == INIT) begin
      ptr_d = ptr_q + AW'(1);
      if (ptr_q == AW'(DEPTH - 1)) state_d = RUN;
    end
  end

  // Per-entry update: ascending port loops make the highest write port win,
  // and the alloc loop runs last so a new producer overrides a same-cycle writeback.
  always_comb begin
    pend_d = pend_q;
    wr_hit = '0;
    for (int e = 0; e < DEPTH; e++) begin
      wr_dat[e] = '0;
      if (state_q == RUN && !(ZERO_REG != 0 && e == 0)) begin
        for (int i = 0; i < WRITE_PORTS; i++) begin
          if (We[i] && WA[i] == AW'(e)) begin
            wr_hit[e] = 1'b1;
            wr_dat[e] = WD[i];
            pend_d[e] = 1'b0;
          end
        end
        for (int k = 0; k < ALLOC_PORTS; k++) begin
          if (Ae[k] && AA[k] == AW'(e)) pend_d[e] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT;
      ptr_q   <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      pend_q  <= pend_d;
    end
  end

  // Array has no reset; the INIT sweep zeroes it one entry per cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == INIT) begin
        mem_q[ptr_q] <= '0;
      end else begin
        for (int e = 0; e < DEPTH; e++) begin
          if (wr_hit[e]) mem_q[e] <= wr_dat[e];
        end
      end
    end
  end

  assign ready = (state_q == RUN);

  for (genvar j = 0; j < READ_PORTS; j++) begin : g_rd
    logic [WIDTH-1:0] rd;
    logic             rp;
`ifdef REGFILE_BYPASS_EN
    logic             wr_fwd;
    logic             al_fwd;
`endif
    always_comb begin
      rd = '0;
      rp = 1'b0;
`ifdef REGFILE_BYPASS_EN
      wr_fwd = 1'b0;
      al_fwd = 1'b0;
`endif
      if (state_q == RUN && 32'(RA[j]) < DEPTH && !(ZERO_REG != 0 && RA[j] == '0)) begin
        rd = mem_q[RA[j]];
        rp = pend_q[RA[j]];
`ifdef REGFILE_BYPASS_EN
        for (int i = 0; i < WRITE_PORTS; i++) begin
          if (We[i] && WA[i] == RA[j]) begin
            wr_fwd = 1'b1;
            rd     = WD[i];
          end
        end
        for (int k = 0; k < ALLOC_PORTS; k++) begin
          if (Ae[k] && AA[k] == RA[j]) al_fwd = 1'b1;
        end
        if (wr_fwd) rp = al_fwd;
`endif
      end
    end
    assign RD[j] = rd;
    assign RP[j] = rp;
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed scenarios plus randomized traffic
// checked against an array-based model of the register file and scoreboard.
module tb_regfile_sb;
  localparam int RP_N = 8, WP_N = 4, AP_N = 4, W = 32, D = 64, AW = 6;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [RP_N-1:0][AW-1:0] RA;
  logic [RP_N-1:0][W-1:0]  RD;
  logic [RP_N-1:0]         RP;
  logic [WP_N-1:0][AW-1:0] WA;
  logic [WP_N-1:0][W-1:0]  WD;
  logic [WP_N-1:0]         We;
  logic [AP_N-1:0][AW-1:0] AA;
  logic [AP_N-1:0]         Ae;
  logic                    ready;

  int errors = 0;
  int checks = 0;

  // reference model state
  logic [W-1:0] m_mem  [D];
  logic         m_pend [D];
  logic         m_ready = 1'b0;
  int           m_sweep = 0;

  regfile_sb dut (
    .clk(clk), .rst(rst), .RA(RA), .RD(RD), .RP(RP), .WA(WA), .WD(WD), .We(We),
    .AA(AA), .Ae(Ae), .ready(ready)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] m_rd(input int j);
    int a;
    logic [W-1:0] d;
    a = int'(RA[j]);
    if (!m_ready || a == 0) return '0;
    d = m_mem[a];
`ifdef REGFILE_BYPASS_EN
    for (int i = 0; i < WP_N; i++) if (We[i] && int'(WA[i]) == a) d = WD[i];
`endif
    return d;
  endfunction

  function automatic logic m_rp(input int j);
    int a;
    logic p;
    a = int'(RA[j]);
    if (!m_ready || a == 0) return 1'b0;
    p = m_pend[a];
`ifdef REGFILE_BYPASS_EN
    begin
      logic hit, al;
      hit = 1'b0; al = 1'b0;
      for (int i = 0; i < WP_N; i++) if (We[i] && int'(WA[i]) == a) hit = 1'b1;
      for (int k = 0; k < AP_N; k++) if (Ae[k] && int'(AA[k]) == a) al = 1'b1;
      if (hit) p = al;
    end
`endif
    return p;
  endfunction

  // Advance the model by one clock edge using the currently driven inputs, then clock the DUT.
  task automatic tick();
    if (rst) begin
      m_ready = 1'b0;
      m_sweep = D;
      for (int e = 0; e < D; e++) m_pend[e] = 1'b0;
    end else if (!m_ready) begin
      m_sweep--;
      if (m_sweep == 0) begin
        m_ready = 1'b1;
        for (int e = 0; e < D; e++) m_mem[e] = '0;
      end
    end else begin
      for (int i = 0; i < WP_N; i++)
        if (We[i] && WA[i] != 0) begin
          m_mem[WA[i]] = WD[i];
          m_pend[WA[i]] = 1'b0;
        end
      for (int k = 0; k < AP_N; k++)
        if (Ae[k] && AA[k] != 0) m_pend[AA[k]] = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    We = '0; Ae = '0; WA = '0; WD = '0; AA = '0;
  endtask

  task automatic randomize_ports();
    for (int j = 0; j < RP_N; j++) RA[j] = AW'($urandom_range(0, D - 1));
    for (int i = 0; i < WP_N; i++) begin
      WA[i] = AW'($urandom_range(0, 15));
      WD[i] = $urandom;
    end
    for (int k = 0; k < AP_N; k++) AA[k] = AW'($urandom_range(0, 15));
    We = WP_N'($urandom);
    Ae = AP_N'($urandom) & AP_N'($urandom);
  endtask

  task automatic test_reset();
    int cnt;
    rst = 1'b1;
    randomize_ports();
    tick();
    rst = 1'b0;
    cnt = 0;
    while (!ready && cnt < 200) begin
      randomize_ports();
      #1;
      for (int j = 0; j < RP_N; j++) begin
        checks++;
        if (RD[j] !== m_rd(j) || RP[j] !== m_rp(j))
          $display("FAIL init_read port %0d: RD=%h RP=%b want RD=%h RP=%b", j, RD[j], RP[j], m_rd(j), m_rp(j));
        if (RD[j] !== m_rd(j) || RP[j] !== m_rp(j)) errors++;
      end
      tick();
      cnt++;
    end
    checks++;
    if (cnt !== D) begin
      errors++;
      $display("FAIL sweep_len: got %0d cycles want %0d", cnt, D);
    end
    idle();
    for (int g = 0; g < D / RP_N; g++) begin
      for (int j = 0; j < RP_N; j++) RA[j] = AW'(g * RP_N + j);
      #1;
      for (int j = 0; j < RP_N; j++) begin
        checks++;
        if (RD[j] !== '0 || RP[j] !== 1'b0) begin
          errors++;
          $display("FAIL post_sweep entry %0d: RD=%h RP=%b want 0/0", g * RP_N + j, RD[j], RP[j]);
        end
      end
    end
  endtask

  task automatic test_alloc_write();
    idle();
    RA = '0; RA[0] = 6'd5;
    Ae[0] = 1'b1; AA[0] = 6'd5;
    tick();
    idle();
    checks++;
    if (RP[0] !== 1'b1) begin errors++; $display("FAIL alloc_pend: RP=%b want 1", RP[0]); end
    We[1] = 1'b1; WA[1] = 6'd5; WD[1] = 32'hDEADBEEF;
    #1;
    checks++;
    if (RD[0] !== m_rd(0) || RP[0] !== m_rp(0)) begin
      errors++;
      $display("FAIL wb_same_cycle: RD=%h RP=%b want RD=%h RP=%b", RD[0], RP[0], m_rd(0), m_rp(0));
    end
    tick();
    idle();
    checks++;
    if (RD[0] !== 32'hDEADBEEF || RP[0] !== 1'b0) begin
      errors++;
      $display("FAIL wb_data: RD=%h RP=%b want DEADBEEF/0", RD[0], RP[0]);
    end
  endtask

  task automatic test_write_priority();
    idle();
    RA[2] = 6'd7;
    We[0] = 1'b1; WA[0] = 6'd7; WD[0] = 32'h11;
    We[3] = 1'b1; WA[3] = 6'd7; WD[3] = 32'h33;
    tick();
    idle();
    checks++;
    if (RD[2] !== 32'h33) begin errors++; $display("FAIL write_prio: RD=%h want 33", RD[2]); end
  endtask

  task automatic test_zero_reg();
    idle();
    RA[3] = 6'd0;
    We[2] = 1'b1; WA[2] = 6'd0; WD[2] = 32'hFFFF;
    Ae[1] = 1'b1; AA[1] = 6'd0;
    #1;
    checks++;
    if (RD[3] !== '0 || RP[3] !== 1'b0) begin
      errors++;
      $display("FAIL zero_same: RD=%h RP=%b want 0/0", RD[3], RP[3]);
    end
    tick();
    idle();
    checks++;
    if (RD[3] !== '0 || RP[3] !== 1'b0) begin
      errors++;
      $display("FAIL zero_next: RD=%h RP=%b want 0/0", RD[3], RP[3]);
    end
  endtask

  task automatic test_alloc_and_write();
    idle();
    RA[4] = 6'd9;
    We[0] = 1'b1; WA[0] = 6'd9; WD[0] = 32'h42;
    Ae[3] = 1'b1; AA[3] = 6'd9;
    tick();
    idle();
    checks++;
    if (RD[4] !== 32'h42 || RP[4] !== 1'b1) begin
      errors++;
      $display("FAIL alloc_wins: RD=%h RP=%b want 42/1", RD[4], RP[4]);
    end
`ifdef REGFILE_BYPASS_EN
    We[1] = 1'b1; WA[1] = 6'd3; WD[1] = 32'hA5;
    RA[5] = 6'd3;
    #1;
    checks++;
    if (RD[5] !== 32'hA5 || RP[5] !== 1'b0) begin
      errors++;
      $display("FAIL bypass: RD=%h RP=%b want A5/0", RD[5], RP[5]);
    end
    tick();
    idle();
`endif
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      randomize_ports();
      #1;
      for (int j = 0; j < RP_N; j++) begin
        checks++;
        if (RD[j] !== m_rd(j) || RP[j] !== m_rp(j)) begin
          errors++;
          $display("FAIL random c%0d port %0d RA=%0d: RD=%h RP=%b want RD=%h RP=%b",
                   c, j, RA[j], RD[j], RP[j], m_rd(j), m_rp(j));
        end
      end
      tick();
    end
    idle();
  endtask

  task automatic test_reset_restart();
    int cnt;
    // reset pulse in RUN: scoreboard cleared, ready drops
    for (int j = 0; j < RP_N; j++) RA[j] = AW'(j + 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (ready !== 1'b0 || RP !== '0) begin
      errors++;
      $display("FAIL run_reset: ready=%b RP=%b want 0/0", ready, RP);
    end
    for (int c = 0; c < 20; c++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cnt = 0;
    while (!ready && cnt < 200) begin
      tick();
      cnt++;
    end
    checks++;
    if (cnt !== D) begin
      errors++;
      $display("FAIL sweep_restart: got %0d cycles want %0d", cnt, D);
    end
    #1;
    for (int j = 0; j < RP_N; j++) begin
      checks++;
      if (RD[j] !== m_rd(j) || RP[j] !== m_rp(j)) begin
        errors++;
        $display("FAIL restart_read port %0d: RD=%h RP=%b want RD=%h RP=%b", j, RD[j], RP[j], m_rd(j), m_rp(j));
      end
    end
  endtask

  initial begin
    RA = '0;
    idle();
    @(posedge clk);
    #1;
    test_reset();
    test_alloc_write();
    test_write_priority();
    test_zero_reg();
    test_alloc_and_write();
    test_random();
    test_reset_restart();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
